// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the IO read arbiter
package io_pkg;

    // Default addr[7:2] codes of the two input-register ports (0xC0 / 0xC4).
    localparam logic [5:0] PORT0_SEL_DEF = 6'b110000;
    localparam logic [5:0] PORT1_SEL_DEF = 6'b110001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        ID_M0 = 1'b0,
        ID_M1 = 1'b1
    } req_id_t;

    // True when the byte address selects one of the two mapped input ports.
    function automatic logic sel_match(input logic [31:0] addr,
                                       input logic [5:0]  sel0,
                                       input logic [5:0]  sel1);
        return (addr[7:2] == sel0) || (addr[7:2] == sel1);
    endfunction

endpackage

// File: rtl/io_rr_pick.sv
// rtl/io_rr_pick.sv - two-way round-robin winner select
//   req[1:0] : pending requests (bit 0 = m0, bit 1 = m1)
//   last_id  : requester granted most recently
//   win_id   : requester to grant now (only meaningful when req != 0)
module io_rr_pick
    import io_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_id,
    output req_id_t    win_id
);

    always_comb begin
        win_id = ID_M0;
        if (req == 2'b11) begin
            // On a tie, hand the grant to whoever did not have it last.
            win_id = (last_id == ID_M0) ? ID_M1 : ID_M0;
        end else if (req[1]) begin
            win_id = ID_M1;
        end
    end

endmodule

// File: rtl/io_read_arbiter.sv
// rtl/io_read_arbiter.sv - arbitrates two read requesters onto one input-register block
//   Optional feature macro: IO_ARB_ERR_EN (unmapped-address error response, adds rerr).
//   Ports:
//     io_clk, reset            : clock, asynchronous active-high reset
//     m0_req/m0_addr, m1_req/m1_addr : read requests (held until gnt)
//     m0_gnt, m1_gnt           : one-cycle acceptance pulses
//     m0_rvalid, m1_rvalid     : one-cycle read-data-valid pulses
//     rdata                    : shared read data, valid with an rvalid
//     io_addr, io_read_data    : address to / data from the input-register block
//     rerr                     : unmapped-address flag with rvalid (IO_ARB_ERR_EN only)
module io_read_arbiter
    import io_pkg::*;
#(
    parameter logic [5:0] PORT0_SEL   = PORT0_SEL_DEF,
    parameter logic [5:0] PORT1_SEL   = PORT1_SEL_DEF,
    parameter int         WAIT_CYCLES = 1
)
(
    input  logic        io_clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] io_addr,
`ifdef IO_ARB_ERR_EN
    output logic        rerr,
`endif
    input  logic [31:0] io_read_data
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

    state_t      state;
    req_id_t     owner;
    req_id_t     last_id;
    req_id_t     win_id;
    logic [2:0]  wait_cnt;
    logic [31:0] win_addr;
    logic        win_mapped;

    io_rr_pick u_pick (
        .req     ({m1_req, m0_req}),
        .last_id (last_id),
        .win_id  (win_id)
    );

    assign win_addr   = (win_id == ID_M1) ? m1_addr : m0_addr;
    assign win_mapped = sel_match(win_addr, PORT0_SEL, PORT1_SEL);

`ifdef IO_ARB_ERR_EN
    logic err_pend;
`else
    // Without the error feature every address takes the normal path.
    logic unused_win_mapped;
    assign unused_win_mapped = win_mapped;
`endif

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            rdata     <= '0;
            io_addr   <= '0;
            wait_cnt  <= '0;
            owner     <= ID_M0;
            // Pointing at m1 makes the first tie go to m0.
            last_id   <= ID_M1;
`ifdef IO_ARB_ERR_EN
            err_pend  <= 1'b0;
            rerr      <= 1'b0;
`endif
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
`ifdef IO_ARB_ERR_EN
            rerr      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        m0_gnt   <= (win_id == ID_M0);
                        m1_gnt   <= (win_id == ID_M1);
                        io_addr  <= win_addr;
                        owner    <= win_id;
                        last_id  <= win_id;
                        wait_cnt <= WAIT_LOAD;
`ifdef IO_ARB_ERR_EN
                        // Unmapped addresses answer immediately with an error.
                        err_pend <= !win_mapped;
                        state    <= win_mapped ? WAIT : RESP;
`else
                        state    <= WAIT;
`endif
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
`ifdef IO_ARB_ERR_EN
                    rdata <= err_pend ? 32'd0 : io_read_data;
                    rerr  <= err_pend;
`else
                    rdata <= io_read_data;
`endif
                    m0_rvalid <= (owner == ID_M0);
                    m1_rvalid <= (owner == ID_M1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_read_arbiter.sv
// tb/tb_io_read_arbiter.sv - directed self-checking bench for io_read_arbiter
module tb_io_read_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: WAIT_CYCLES = 1
    logic        a_m0_req, a_m1_req;
    logic [31:0] a_m0_addr, a_m1_addr;
    logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid;
    logic [31:0] a_rdata, a_io_addr, a_io_read_data;
`ifdef IO_ARB_ERR_EN
    logic        a_rerr;
    logic        b_rerr;
`endif

    // DUT B: WAIT_CYCLES = 4
    logic        b_m0_req, b_m1_req;
    logic [31:0] b_m0_addr, b_m1_addr;
    logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
    logic [31:0] b_rdata, b_io_addr, b_io_read_data;

    io_read_arbiter #(.WAIT_CYCLES(1)) dut_a (
        .io_clk       (clk),
        .reset        (reset),
        .m0_req       (a_m0_req),
        .m0_addr      (a_m0_addr),
        .m1_req       (a_m1_req),
        .m1_addr      (a_m1_addr),
        .m0_gnt       (a_m0_gnt),
        .m1_gnt       (a_m1_gnt),
        .m0_rvalid    (a_m0_rvalid),
        .m1_rvalid    (a_m1_rvalid),
        .rdata        (a_rdata),
        .io_addr      (a_io_addr),
`ifdef IO_ARB_ERR_EN
        .rerr         (a_rerr),
`endif
        .io_read_data (a_io_read_data)
    );

    io_read_arbiter #(.WAIT_CYCLES(4)) dut_b (
        .io_clk       (clk),
        .reset        (reset),
        .m0_req       (b_m0_req),
        .m0_addr      (b_m0_addr),
        .m1_req       (b_m1_req),
        .m1_addr      (b_m1_addr),
        .m0_gnt       (b_m0_gnt),
        .m1_gnt       (b_m1_gnt),
        .m0_rvalid    (b_m0_rvalid),
        .m1_rvalid    (b_m1_rvalid),
        .rdata        (b_rdata),
        .io_addr      (b_io_addr),
`ifdef IO_ARB_ERR_EN
        .rerr         (b_rerr),
`endif
        .io_read_data (b_io_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int          g[$];
        int          both;
        int          gc;
        int          rc;
        int          addr_bad;
        int          rv_seen;
        logic [5:0]  seq;

        reset = 1'b1;
        a_m0_req = 0; a_m1_req = 0; a_m0_addr = 0; a_m1_addr = 0; a_io_read_data = 0;
        b_m0_req = 0; b_m1_req = 0; b_m0_addr = 0; b_m1_addr = 0; b_io_read_data = 0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_a_ctl", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_a_io_addr", a_io_addr, 32'd0);
        chk("rst_b_ctl", {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read on A: gnt cycle 0, rvalid cycle 2
        a_m0_req = 1; a_m0_addr = 32'hC0; a_io_read_data = 32'h1234;
        @(negedge clk);
        chk("single_m0_gnt", a_m0_gnt, 1);
        chk("single_m1_gnt", a_m1_gnt, 0);
        chk("single_io_addr", a_io_addr, 32'hC0);
        a_m0_req = 0; a_m0_addr = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("single_rvalid_c1", {a_m0_rvalid, a_m1_rvalid}, 0);
        @(negedge clk);
        chk("single_m0_rvalid", a_m0_rvalid, 1);
        chk("single_m1_rvalid", a_m1_rvalid, 0);
        chk("single_rdata", a_rdata, 32'h1234);
        a_io_read_data = 32'h9999;
        @(negedge clk);
        chk("single_rvalid_drop", {a_m0_rvalid, a_m1_rvalid}, 0);
        chk("rdata_hold", a_rdata, 32'h1234);
        chk("io_addr_hold", a_io_addr, 32'hC0);

        // Tie after reset: m0 first, then m1, rvalids 3 cycles apart
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_m0_req = 1; a_m0_addr = 32'hC0; a_m1_req = 1; a_m1_addr = 32'hC4;
        a_io_read_data = 32'hAAAA;
        @(negedge clk);                          // cycle 0
        chk("tie_first_gnt", {a_m1_gnt, a_m0_gnt}, 32'b01);
        chk("tie_first_addr", a_io_addr, 32'hC0);
        a_m0_req = 0;
        @(negedge clk);                          // cycle 1
        @(negedge clk);                          // cycle 2
        chk("tie_first_rvalid", {a_m1_rvalid, a_m0_rvalid}, 32'b01);
        chk("tie_first_rdata", a_rdata, 32'hAAAA);
        a_io_read_data = 32'hBBBB;
        @(negedge clk);                          // cycle 3
        chk("tie_second_gnt", {a_m1_gnt, a_m0_gnt}, 32'b10);
        chk("tie_second_addr", a_io_addr, 32'hC4);
        a_m1_req = 0;
        @(negedge clk);                          // cycle 4
        @(negedge clk);                          // cycle 5
        chk("tie_second_rvalid", {a_m1_rvalid, a_m0_rvalid}, 32'b10);
        chk("tie_second_rdata", a_rdata, 32'hBBBB);

        // Fairness: both hold requests for 6 transactions
        a_m0_req = 1; a_m1_req = 1;
        both = 0;
        for (int i = 0; i < 30 && g.size() < 6; i++) begin
            @(negedge clk);
            if (a_m0_gnt && a_m1_gnt) both++;
            if (a_m0_rvalid && a_m1_rvalid) both++;
            if (a_m0_gnt) g.push_back(0);
            if (a_m1_gnt) g.push_back(1);
        end
        a_m0_req = 0; a_m1_req = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_m0_rvalid && a_m1_rvalid) both++;
        end
        seq = '0;
        for (int k = 0; k < g.size() && k < 6; k++) seq[k] = g[k][0];
        chk("fair_count", g.size(), 6);
        chk("fair_order", {26'd0, seq}, 32'b101010);
        chk("fair_no_dual", both, 0);

        // Unmapped address 0xC8
        a_m0_req = 1; a_m0_addr = 32'hC8; a_io_read_data = 32'hFFFF_0000;
        @(negedge clk);
        chk("unmap_gnt", a_m0_gnt, 1);
        a_m0_req = 0;
        @(negedge clk);
`ifdef IO_ARB_ERR_EN
        chk("unmap_rvalid", a_m0_rvalid, 1);
        chk("unmap_rdata", a_rdata, 32'd0);
        chk("unmap_rerr", a_rerr, 1);
        @(negedge clk);
        chk("unmap_rerr_drop", {a_rerr, a_m0_rvalid}, 0);
`else
        chk("unmap_rvalid_c1", a_m0_rvalid, 0);
        @(negedge clk);
        chk("unmap_rvalid", a_m0_rvalid, 1);
        chk("unmap_rdata", a_rdata, 32'hFFFF_0000);
`endif

        // DUT B, WAIT_CYCLES=4: m1 reads 0xC4, rvalid 5 cycles after gnt
        b_m1_req = 1; b_m1_addr = 32'hC4; b_io_read_data = 32'h5A5A;
        gc = -1; rc = -1; addr_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_m1_gnt && gc < 0) begin
                gc = i;
                b_m1_req = 0;
                b_m1_addr = 32'h0;
            end
            if (gc >= 0 && rc < 0 && b_io_addr !== 32'hC4) addr_bad++;
            if (b_m1_rvalid && rc < 0) rc = i;
        end
        chk("w4_gnt_cycle", gc, 0);
        chk("w4_latency", rc - gc, 5);
        chk("w4_addr_stable", addr_bad, 0);
        chk("w4_rdata", b_rdata, 32'h5A5A);

        // Reset one cycle after gnt on B (state WAIT)
        b_m0_req = 1; b_m0_addr = 32'hC0;
        @(negedge clk);
        chk("rstw_gnt", b_m0_gnt, 1);
        b_m0_req = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstw_ctl", {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid}, 0);
        chk("rstw_rdata", b_rdata, 32'd0);
        chk("rstw_io_addr", b_io_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rv_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_m0_rvalid || b_m1_rvalid) rv_seen++;
        end
        chk("rstw_no_rvalid", rv_seen, 0);
        b_m0_req = 1; b_m1_req = 1; b_m1_addr = 32'hC4;
        @(negedge clk);
        chk("rstw_tie_m0", {b_m1_gnt, b_m0_gnt}, 32'b01);
        b_m0_req = 0; b_m1_req = 0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
